// File: rtl/pressure_sensor_receiver.sv
// Serial receiver for framed 6-bit pressure samples: start, 6 data bits LSB first, even parity, stop.
// Good samples update pressureData with a dataValid strobe; bad frames are flagged and counted.
module pressure_sensor_receiver #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serialIn,
  output logic [5:0] pressureData,
  output logic       dataValid,
  output logic       parityError,
  output logic       frameError,
  output logic [7:0] errorCount
);

  localparam int unsigned H    = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(H - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rxStateT;

  rxStateT         state;
  logic [CntW-1:0] cnt;
  logic [2:0]      idx;
  logic [5:0]      shiftReg;
  logic            parityBit;
  logic            syncA;
  logic            s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA <= 1'b1;
      s     <= 1'b1;
    end else begin
      syncA <= serialIn;
      s     <= syncA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= '0;
      idx          <= '0;
      shiftReg     <= '0;
      parityBit    <= 1'b0;
      pressureData <= '0;
      dataValid    <= 1'b0;
      parityError  <= 1'b0;
      frameError   <= 1'b0;
      errorCount   <= '0;
    end else begin
      dataValid   <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      case (state)
        StIdle: begin
          if (!s) begin
            state <= StStart;
            cnt   <= '0;
          end
        end
        StStart: begin
          if (cnt == CntHalf) begin
            cnt <= '0;
            if (!s) begin
              state <= StData;
              idx   <= '0;
            end else begin
              state <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == CntLast) begin
            cnt      <= '0;
            // LSB arrives first, so after six shifts bit 0 sits at the bottom.
            shiftReg <= {s, shiftReg[5:1]};
            if (idx == 3'd5) begin
              state <= StParity;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StParity: begin
          if (cnt == CntLast) begin
            cnt       <= '0;
            parityBit <= s;
            state     <= StStop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          if (cnt == CntLast) begin
            cnt <= '0;
            if (s) begin
              state <= StIdle;
              if (^{shiftReg, parityBit}) begin
                parityError <= 1'b1;
                if (errorCount != 8'hFF) errorCount <= errorCount + 8'd1;
              end else begin
                pressureData <= shiftReg;
                dataValid    <= 1'b1;
              end
            end else begin
              // A low stop bit outranks any parity problem.
              frameError <= 1'b1;
              if (errorCount != 8'hFF) errorCount <= errorCount + 8'd1;
              state <= StWaitHigh;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StWaitHigh: begin
          if (s) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pressure_sensor_receiver.sv
// Self-checking bench for pressure_sensor_receiver: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_pressure_sensor_receiver;

  localparam int CPB  = 4;
  localparam int SE   = 2 + CPB / 2 + 8 * CPB;   // stop-sample edge relative to E0
  localparam int GAP1 = 10 * CPB - (SE + 2);     // idle edges giving exactly one idle bit time

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serialIn = 1'b1;
  logic [5:0] pressureData;
  logic       dataValid;
  logic       parityError;
  logic       frameError;
  logic [7:0] errorCount;

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] modelData = '0;
  int modelCount = 0;

  pressure_sensor_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .serialIn(serialIn),
    .pressureData(pressureData),
    .dataValid(dataValid),
    .parityError(parityError),
    .frameError(frameError),
    .errorCount(errorCount)
  );

  always #5 clk = ~clk;

  // Drives one frame starting after `idle` more edges and checks the whole outcome at the
  // stop-sample edge; the model is updated from the frame contents alone.
  task automatic sendFrame(input logic [5:0] d, input logic p, input logic stopBit, input int idle);
    logic [8:0] bits;
    logic expGood, expPar, expFrame;
    int spurious;
    bits     = {stopBit, p, d, 1'b0};
    expFrame = !stopBit;
    expPar   = stopBit && (^{d, p});
    expGood  = stopBit && !(^{d, p});
    if (expGood) modelData = d;
    if (!expGood && modelCount < 255) modelCount++;
    spurious = 0;
    repeat (idle) @(posedge clk);
    #1;
    for (int e = 0; e <= SE + 1; e++) begin
      serialIn = (e / CPB < 9) ? bits[e / CPB] : stopBit;
      @(posedge clk);
      #1;
      if (e == SE) begin
        vectors++;
        if (dataValid !== expGood) begin
          miscompares++;
          $display("FAIL dataValid d=%b p=%b stop=%b: got %b expected %b", d, p, stopBit,
                   dataValid, expGood);
        end
        vectors++;
        if (parityError !== expPar) begin
          miscompares++;
          $display("FAIL parityError d=%b p=%b stop=%b: got %b expected %b", d, p, stopBit,
                   parityError, expPar);
        end
        vectors++;
        if (frameError !== expFrame) begin
          miscompares++;
          $display("FAIL frameError d=%b p=%b stop=%b: got %b expected %b", d, p, stopBit,
                   frameError, expFrame);
        end
        vectors++;
        if (pressureData !== modelData) begin
          miscompares++;
          $display("FAIL pressureData d=%b: got %b expected %b", d, pressureData, modelData);
        end
        vectors++;
        if (errorCount !== 8'(modelCount)) begin
          miscompares++;
          $display("FAIL errorCount d=%b: got %0d expected %0d", d, errorCount, modelCount);
        end
      end else if (dataValid || parityError || frameError) begin
        spurious++;
      end
    end
    vectors++;
    if (spurious != 0) begin
      miscompares++;
      $display("FAIL strobeTiming d=%b: got %0d off-edge strobes expected 0", d, spurious);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({pressureData, dataValid, parityError, frameError, errorCount} !== 17'd0) begin
      miscompares++;
      $display("FAIL resetState: got data=%b dv=%b pe=%b fe=%b cnt=%0d expected all 0",
               pressureData, dataValid, parityError, frameError, errorCount);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    sendFrame(6'b010101, 1'b1, 1'b1, 2);
  endtask

  task automatic test_back_to_back();
    sendFrame(6'b000001, 1'b1, 1'b1, GAP1);
    sendFrame(6'b110001, 1'b1, 1'b1, GAP1);
    sendFrame(6'b100000, 1'b1, 1'b1, GAP1);
  endtask

  task automatic test_parity_error();
    sendFrame(6'b001000, 1'b0, 1'b1, 3);
  endtask

  task automatic test_frame_error();
    int spurious;
    for (int k = 0; k < 2; k++) begin
      // First with good parity, then with bad parity: only frameError may fire.
      sendFrame(k == 0 ? 6'b100110 : 6'b000011, 1'b1, 1'b0, 3);
      spurious = 0;
      repeat (50) begin
        @(posedge clk);
        #1;
        if (dataValid || parityError || frameError) spurious++;
      end
      vectors++;
      if (spurious != 0 || errorCount !== 8'(modelCount)) begin
        miscompares++;
        $display("FAIL stuckLow: got %0d strobes cnt=%0d expected 0 strobes cnt=%0d", spurious,
                 errorCount, modelCount);
      end
      serialIn = 1'b1;
      sendFrame(6'b001011, 1'b1, 1'b1, 4);
    end
  endtask

  task automatic test_glitch();
    int spurious;
    @(posedge clk);
    #1 serialIn = 1'b0;
    @(posedge clk);
    #1 serialIn = 1'b1;
    spurious = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (dataValid || parityError || frameError) spurious++;
    end
    vectors++;
    if (spurious != 0 || errorCount !== 8'(modelCount) || pressureData !== modelData) begin
      miscompares++;
      $display("FAIL glitch: got %0d strobes cnt=%0d data=%b expected 0 cnt=%0d data=%b",
               spurious, errorCount, pressureData, modelCount, modelData);
    end
    sendFrame(6'b111111, 1'b0, 1'b1, 2);
  endtask

  task automatic test_random();
    logic [5:0] d;
    logic p, stopBit, prevStop;
    prevStop = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d       = 6'($urandom);
      stopBit = ($urandom_range(0, 5) != 0);
      p       = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      if (!prevStop) serialIn = 1'b1;
      sendFrame(d, p, stopBit, prevStop ? $urandom_range(GAP1, 10) : $urandom_range(4, 10));
      prevStop = stopBit;
    end
    serialIn = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] bits;
    bits = {1'b1, 1'b1, 6'b101010, 1'b0};
    @(posedge clk);
    #1;
    // Stop partway into data bit 3.
    for (int e = 0; e < 4 * CPB + 2; e++) begin
      serialIn = bits[e / CPB];
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({pressureData, dataValid, parityError, frameError, errorCount} !== 17'd0) begin
      miscompares++;
      $display("FAIL midFrameReset: got data=%b dv=%b pe=%b fe=%b cnt=%0d expected all 0",
               pressureData, dataValid, parityError, frameError, errorCount);
    end
    serialIn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    modelData  = '0;
    modelCount = 0;
    sendFrame(6'b011001, 1'b1, 1'b1, 3);
  endtask

  task automatic test_saturation();
    logic [5:0] d;
    for (int n = 0; n < 260; n++) begin
      d = 6'($urandom);
      sendFrame(d, ~(^d), 1'b1, GAP1);
    end
    vectors++;
    if (errorCount !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation: got %0d expected 255", errorCount);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_parity_error();
    test_frame_error();
    test_glitch();
    test_random();
    test_reset_mid_frame();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
